// File: rtl/sprite_pkg.sv
// Shared types and screen constants for the sprite datapath.
// Sprite geometry and the visible-area limits used by the sprite blocks.
package sprite_pkg;

    localparam int SPR_SIZE = 32;
    localparam int H_VIS    = 640;
    localparam int V_VIS    = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   flip;
    } sprite_pos_t;

endpackage

// File: rtl/sprite_locator.sv
// Maps the VGA scan position into local sprite-ROM coordinates with a hit flag.
// The sprite origin is double-buffered and committed on frame_start so a frame never tears.
module sprite_locator
    import sprite_pkg::*;
#(
    parameter int SIZE     = SPR_SIZE,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 0,
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_valid,
    input  logic       frame_start,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic       pos_flip,
    input  logic       pos_we,
    output logic       pos_pending,
    output logic [9:0] horz,
    output logic [9:0] vert,
    output logic       sprite_hit,
    output logic       anim_sel
);

    localparam int          CNT_W   = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0] SIZE_W  = 11'(SIZE);
    localparam logic [10:0] SIZE_M1 = 11'(SIZE - 1);

    sprite_pos_t shadow;
    sprite_pos_t active;
    sprite_pos_t req;
    logic        pending;

    assign req = '{x: pos_x, y: pos_y, flip: pos_flip};

    // Position handshake: pos_we is a one-cycle write strobe with no back-pressure.
    // Every write is accepted; pos_pending stays high until frame_start commits it.
    // A write coinciding with frame_start bypasses the shadow and lands in active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '{x: coord_t'(INIT_X), y: coord_t'(INIT_Y), flip: 1'b0};
            active  <= '{x: coord_t'(INIT_X), y: coord_t'(INIT_Y), flip: 1'b0};
            pending <= 1'b0;
        end else begin
            if (pos_we) begin
                shadow <= req;
            end
            if (frame_start) begin
                if (pos_we) begin
                    active <= req;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (pos_we) begin
                pending <= 1'b1;
            end
        end
    end

    assign pos_pending = pending;

    logic [CNT_W-1:0] anim_cnt;
    logic             anim_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim_cnt <= '0;
            anim_q   <= 1'b0;
        end else if (frame_start) begin
            if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
                anim_cnt <= '0;
                anim_q   <= ~anim_q;
            end else begin
                anim_cnt <= anim_cnt + CNT_W'(1);
            end
        end
    end

    assign anim_sel = anim_q;

    // S0: scan position capture.
    coord_t s0_x;
    coord_t s0_y;
    logic   s0_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_x     <= '0;
            s0_y     <= '0;
            s0_valid <= 1'b0;
        end else begin
            s0_x     <= pix_x;
            s0_y     <= pix_y;
            s0_valid <= pix_valid;
        end
    end

    // Differences are 11-bit two's complement; bit 10 set means left of / above the origin,
    // so origins near the right/bottom edge clip instead of wrapping.
    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_x;
    logic        in_y;
    logic        hit_c;
    logic [9:0]  horz_c;
    logic [9:0]  vert_c;

    always_comb begin
        dx     = {1'b0, s0_x} - {1'b0, active.x};
        dy     = {1'b0, s0_y} - {1'b0, active.y};
        in_x   = !dx[10] && (dx < SIZE_W);
        in_y   = !dy[10] && (dy < SIZE_W);
        hit_c  = s0_valid && in_x && in_y;
        horz_c = '0;
        vert_c = '0;
        if (hit_c) begin
            horz_c = active.flip ? 10'(SIZE_M1 - dx) : dx[9:0];
            vert_c = dy[9:0];
        end
    end

    // S1: registered ROM address and hit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            horz       <= '0;
            vert       <= '0;
            sprite_hit <= 1'b0;
        end else begin
            horz       <= horz_c;
            vert       <= vert_c;
            sprite_hit <= hit_c;
        end
    end

endmodule
